// File: rtl/multi_frequency_analyzer_pkg.sv
// Shared elaboration-time helpers for the frequency analyzer family.
// Everything here folds to constants; nothing is evaluated at runtime.
package frequency_analyzer_pkg;

   localparam int FREQ_W = 32;

   function automatic int clog2(input longint unsigned value);
      longint unsigned v;
      int              bits;
      v    = value - 64'd1;
      bits = 0;
      while (v > 64'd0) begin
         v    = v >> 1;
         bits = bits + 1;
      end
      return bits;
   endfunction

   function automatic longint unsigned period_cycles(input longint unsigned clock_hz,
                                                     input longint unsigned freq_hz);
      return clock_hz / freq_hz;
   endfunction

   function automatic longint unsigned lo_limit(input longint unsigned period,
                                                input longint unsigned dev_pct);
      return (period * (64'd100 - dev_pct)) / 64'd100;
   endfunction

   function automatic longint unsigned hi_limit(input longint unsigned period,
                                                input longint unsigned dev_pct);
      return (period * (64'd100 + dev_pct)) / 64'd100;
   endfunction

endpackage

// File: rtl/multi_frequency_analyzer_period_meter.sv
// Synchronizes the input, detects rising edges and reports the number of
// enabled clocks between consecutive edges once the meter is armed.
module period_meter #(
   parameter int PW = 16
) (
   input  logic          clock,
   input  logic          clear,
   input  logic          enable,
   input  logic          sample_data,
   output logic          period_valid,
   output logic [PW-1:0] period
);

   logic          sync_p0;
   logic          sync_p1;
   logic          sync_p2;
   logic          armed;
   logic          rise;
   logic [PW-1:0] cnt;

   assign rise = sync_p1 & ~sync_p2;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sync_p0      <= 1'b0;
         sync_p1      <= 1'b0;
         sync_p2      <= 1'b0;
         armed        <= 1'b0;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         // stage p0/p1: metastability filter, p2: previous level for edge detect
         sync_p0      <= sample_data;
         sync_p1      <= sync_p0;
         sync_p2      <= sync_p1;
         period_valid <= 1'b0;
         if (enable) begin
            if (rise) begin
               // first edge after reset or enable rise only arms the meter
               period_valid <= armed;
               period       <= cnt;
               cnt          <= PW'(1);
               armed        <= 1'b1;
            end else if (cnt != '1) begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            armed <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/multi_frequency_analyzer.sv
// Classifies measured input periods into frequency bins, accumulates the
// counts over a fixed window and latches them with a one-cycle strobe.
module multi_frequency_analyzer
   import frequency_analyzer_pkg::*;
#(
   parameter int unsigned                   CLOCK_FREQUENCY   = 100000000,
   parameter int                            NUM_BINS          = 4,
   parameter logic [NUM_BINS*FREQ_W-1:0]    FREQUENCIES       = {32'd40000, 32'd20000, 32'd10000, 32'd5000},
   parameter int unsigned                   DEVIATION_PERCENT = 10,
   parameter int                            COUNTER_WIDTH     = 32,
   parameter int unsigned                   WINDOW_CYCLES     = 1000000
) (
   input  logic                              clock,
   input  logic                              clear,
   input  logic                              enable,
   input  logic                              sample_data,
   output logic [NUM_BINS*COUNTER_WIDTH-1:0] bin_values,
   output logic [COUNTER_WIDTH-1:0]          miss_value,
   output logic [NUM_BINS:0]                 overflow,
   output logic                              result_valid
);

   function automatic longint unsigned max_hi();
      longint unsigned m;
      longint unsigned h;
      m = 64'd0;
      for (int i = 0; i < NUM_BINS; i++) begin
         h = hi_limit(period_cycles(64'(CLOCK_FREQUENCY), 64'(FREQUENCIES[i*FREQ_W +: FREQ_W])),
                      64'(DEVIATION_PERCENT));
         if (h > m) m = h;
      end
      return m;
   endfunction

   localparam int PW = clog2(max_hi() + 64'd2);
   localparam int WW = (WINDOW_CYCLES > 1) ? clog2(64'(WINDOW_CYCLES)) : 1;
   localparam int NA = NUM_BINS + 1;

   function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v,
                                                         input logic inc);
      return (inc && (v != '1)) ? v + 1'b1 : v;
   endfunction

   function automatic logic sat_hit(input logic [COUNTER_WIDTH-1:0] v, input logic inc);
      return inc && (v == '1);
   endfunction

   logic                     period_valid;
   logic [PW-1:0]            period;
   logic [NUM_BINS-1:0]      hit;
   logic [NA-1:0]            inc;
   logic [COUNTER_WIDTH-1:0] acc     [NA];
   logic [COUNTER_WIDTH-1:0] acc_nxt [NA];
   logic [NA-1:0]            ovf;
   logic [NA-1:0]            ovf_nxt;
   logic [WW-1:0]            win_cnt;
   logic                     win_term;

   period_meter #(
      .PW (PW)
   ) u_period_meter (
      .clock        (clock),
      .clear        (clear),
      .enable       (enable),
      .sample_data  (sample_data),
      .period_valid (period_valid),
      .period       (period)
   );

   // stage p1: compare the finished period against every bin window
   for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
      localparam longint unsigned P  = period_cycles(64'(CLOCK_FREQUENCY),
                                                     64'(FREQUENCIES[i*FREQ_W +: FREQ_W]));
      localparam logic [PW-1:0]   LO = PW'(lo_limit(P, 64'(DEVIATION_PERCENT)));
      localparam logic [PW-1:0]   HI = PW'(hi_limit(P, 64'(DEVIATION_PERCENT)));
      assign hit[i] = (period >= LO) && (period <= HI) && (period != '1);
   end

   always_comb begin
      inc = '0;
      if (enable && period_valid) begin
         inc[NUM_BINS] = 1'b1;
         // walk downwards so the lowest matching index wins
         for (int i = NUM_BINS - 1; i >= 0; i--) begin
            if (hit[i]) begin
               inc    = '0;
               inc[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NA; i++) begin
         acc_nxt[i] = sat_inc(acc[i], inc[i]);
         ovf_nxt[i] = ovf[i] | sat_hit(acc[i], inc[i]);
      end
   end

   assign win_term = (win_cnt == WW'(WINDOW_CYCLES - 1));

   // stage p2: accumulate, and on terminal count latch and restart the window
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NA; i++) acc[i] <= '0;
         ovf          <= '0;
         win_cnt      <= '0;
         bin_values   <= '0;
         miss_value   <= '0;
         overflow     <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (enable) begin
            if (win_term) begin
               for (int i = 0; i < NUM_BINS; i++) begin
                  bin_values[i*COUNTER_WIDTH +: COUNTER_WIDTH] <= acc_nxt[i];
               end
               miss_value   <= acc_nxt[NUM_BINS];
               overflow     <= ovf_nxt;
               for (int i = 0; i < NA; i++) acc[i] <= '0;
               ovf          <= '0;
               win_cnt      <= '0;
               result_valid <= 1'b1;
            end else begin
               for (int i = 0; i < NA; i++) acc[i] <= acc_nxt[i];
               ovf     <= ovf_nxt;
               win_cnt <= win_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_frequency_analyzer.sv
// Randomized bench for multi_frequency_analyzer against a period-level
// reference model; scaled clock ratios keep windows short.
module tb_multi_frequency_analyzer;

   localparam int CLK_HZ = 100_000_000;
   localparam int NB     = 4;
   localparam int DEV    = 10;
   localparam int CW     = 6;
   localparam int WIN    = 2000;
   localparam logic [NB*32-1:0] FREQS = {32'd4000000, 32'd2000000, 32'd1000000, 32'd500000};

   logic               clock = 1'b0;
   logic               clear = 1'b0;
   logic               enable = 1'b0;
   logic               sample_data = 1'b0;
   logic [NB*CW-1:0]   bin_values;
   logic [CW-1:0]      miss_value;
   logic [NB:0]        overflow;
   logic               result_valid;

   always #5 clock = ~clock;

   multi_frequency_analyzer #(
      .CLOCK_FREQUENCY   (CLK_HZ),
      .NUM_BINS          (NB),
      .FREQUENCIES       (FREQS),
      .DEVIATION_PERCENT (DEV),
      .COUNTER_WIDTH     (CW),
      .WINDOW_CYCLES     (WIN)
   ) dut (
      .clock        (clock),
      .clear        (clear),
      .enable       (enable),
      .sample_data  (sample_data),
      .bin_values   (bin_values),
      .miss_value   (miss_value),
      .overflow     (overflow),
      .result_valid (result_valid)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model state, expressed in periods and windows
   int     lo_lim [NB];
   int     hi_lim [NB];
   int     pmax;
   int     m_acc [NB+1];
   bit     m_ovf [NB+1];
   int     m_out [NB+1];
   bit     m_out_ovf [NB+1];
   bit     m_valid;
   int     m_win;
   bit     m_armed;
   longint m_last;
   longint cyc;
   int     m_pend;
   bit     h1, h2, h3;

   int blist [19] = '{180, 220, 179, 221, 90, 110, 89, 111, 45, 55, 44, 56,
                      22, 27, 21, 28, 150, 300, 70};
   int hi_left = 0;
   int lo_left = 0;
   int burst_left = 0;

   function automatic int classify(input int p);
      if (p >= pmax) return NB;
      for (int i = 0; i < NB; i++) begin
         if (p >= lo_lim[i] && p <= hi_lim[i]) return i;
      end
      return NB;
   endfunction

   task automatic model_reset();
      for (int i = 0; i <= NB; i++) begin
         m_acc[i] = 0; m_ovf[i] = 0; m_out[i] = 0; m_out_ovf[i] = 0;
      end
      m_valid = 0; m_win = 0; m_armed = 0; m_last = 0; m_pend = -1;
      h1 = 0; h2 = 0; h3 = 0;
   endtask

   task automatic model_step(input bit en, input bit s);
      longint d;
      int     p;
      m_valid = 0;
      if (en && m_pend >= 0) begin
         if (m_acc[m_pend] == (1 << CW) - 1) m_ovf[m_pend] = 1;
         else m_acc[m_pend]++;
      end
      if (en) begin
         if (m_win == WIN - 1) begin
            for (int i = 0; i <= NB; i++) begin
               m_out[i] = m_acc[i]; m_out_ovf[i] = m_ovf[i];
               m_acc[i] = 0;        m_ovf[i] = 0;
            end
            m_valid = 1;
            m_win   = 0;
         end else begin
            m_win++;
         end
      end
      m_pend = -1;
      if (en && h2 && !h3) begin
         if (m_armed) begin
            d = cyc - m_last;
            p = (d > pmax) ? pmax : int'(d);
            m_pend = classify(p);
         end
         m_armed = 1;
         m_last  = cyc;
      end
      if (!en) m_armed = 0;
      h3 = h2; h2 = h1; h1 = s;
      cyc++;
   endtask

   task automatic compare_all();
      logic [NB*CW-1:0] eb;
      logic [NB:0]      eo;
      for (int i = 0; i < NB; i++) eb[i*CW +: CW] = CW'(m_out[i]);
      for (int i = 0; i <= NB; i++) eo[i] = m_out_ovf[i];
      check_val("result_valid", 64'(result_valid), 64'(m_valid));
      check_val("bin_values", 64'(bin_values), 64'(eb));
      check_val("miss_value", 64'(miss_value), 64'(CW'(m_out[NB])));
      check_val("overflow", 64'(overflow), 64'(eo));
   endtask

   function automatic int next_period(input int mode);
      case (mode)
         0:       return 100;
         1:       return blist[$urandom_range(0, 18)];
         2:       return 140;
         default: return 25;
      endcase
   endfunction

   // mode 4 holds the input low; other modes emit whole periods
   task automatic drive_gen(input int mode);
      int p;
      if (mode == 4) begin
         sample_data = 1'b0;
         hi_left = 0;
         lo_left = 0;
      end else begin
         if (hi_left == 0 && lo_left == 0) begin
            p = next_period(mode);
            hi_left = p / 2;
            lo_left = p - p / 2;
         end
         if (hi_left > 0) begin
            sample_data = 1'b1;
            hi_left--;
         end else begin
            sample_data = 1'b0;
            lo_left--;
         end
      end
   endtask

   task automatic run_cycles(input int n, input int mode, input bit bursts);
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         drive_gen(mode);
         if (bursts) begin
            if (burst_left > 0) begin
               enable = 1'b0;
               burst_left--;
            end else if ($urandom_range(0, 999) < 3) begin
               enable = 1'b0;
               burst_left = $urandom_range(1, 400);
            end else begin
               enable = 1'b1;
            end
         end else begin
            enable = 1'b1;
         end
         @(posedge clock);
         model_step(enable, sample_data);
         #1 compare_all();
      end
   endtask

   initial begin
      int maxhi;
      int per;
      maxhi = 0;
      for (int i = 0; i < NB; i++) begin
         per       = CLK_HZ / int'(FREQS[i*32 +: 32]);
         lo_lim[i] = per * (100 - DEV) / 100;
         hi_lim[i] = per * (100 + DEV) / 100;
         if (hi_lim[i] > maxhi) maxhi = hi_lim[i];
      end
      pmax = (1 << $clog2(maxhi + 2)) - 1;
      cyc  = 0;
      model_reset();

      repeat (3) @(posedge clock);
      #1;
      check_val("rst_bins", 64'(bin_values), 64'd0);
      check_val("rst_miss", 64'(miss_value), 64'd0);
      check_val("rst_ovf", 64'(overflow), 64'd0);
      check_val("rst_valid", 64'(result_valid), 64'd0);
      @(negedge clock);
      clear = 1'b1;

      run_cycles(3 * WIN, 0, 1'b0);
      check_val("steady_bin1", 64'(bin_values[CW +: CW]), 64'd20);
      check_val("steady_miss", 64'(miss_value), 64'd0);

      run_cycles(4 * WIN, 1, 1'b0);
      run_cycles(2 * WIN, 2, 1'b0);
      check_val("offband_bins", 64'(bin_values), 64'd0);

      run_cycles(2 * WIN, 3, 1'b0);
      check_val("sat_bin3", 64'(bin_values[3*CW +: CW]), 64'((1 << CW) - 1));
      check_val("sat_ovf3", 64'(overflow[3]), 64'd1);

      run_cycles(2 * WIN, 4, 1'b0);
      check_val("idle_ovf", 64'(overflow), 64'd0);
      check_val("idle_bins", 64'(bin_values), 64'd0);

      run_cycles(5 * WIN, 0, 1'b1);
      enable = 1'b1;
      burst_left = 0;
      run_cycles(700, 0, 1'b0);

      @(posedge clock);
      model_step(enable, sample_data);
      #3 clear = 1'b0;
      #1;
      check_val("async_clr_bins", 64'(bin_values), 64'd0);
      check_val("async_clr_miss", 64'(miss_value), 64'd0);
      check_val("async_clr_ovf", 64'(overflow), 64'd0);
      model_reset();
      repeat (3) begin
         @(posedge clock);
         #1 check_val("in_clr_valid", 64'(result_valid), 64'd0);
      end
      #2 clear = 1'b1;
      run_cycles(WIN + 100, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_frequency_analyzer.md
# multi_frequency_analyzer

Parametrised successor to the two-tone frequency analyzer. It measures the period of a 1-bit input in system clocks and classifies each complete period into one of NUM_BINS frequency bins, each with its own tolerance. Per-bin and unmatched period counts accumulate over a fixed measurement window, then are latched to the outputs with a one-cycle valid strobe. It sits downstream of the pixel/sample capture path and feeds status registers or a decoder.

## Interface
- CLOCK_FREQUENCY, 100000000: clock rate in Hz; used only at elaboration.
- NUM_BINS, 4: number of target frequencies (1..8).
- FREQUENCIES, {32'd40000,32'd20000,32'd10000,32'd5000}: packed 32-bit target frequencies in Hz. Bin 0 occupies the LSBs.
- DEVIATION_PERCENT, 10: tolerance applied to each target period, in percent (0..50).
- COUNTER_WIDTH, 32: width of each result counter.
- WINDOW_CYCLES, 1000000: measurement window length in enabled clock cycles.
- clock  input  1  system clock; all logic is rising-edge.
- clear  input  1  asynchronous, active-low reset.
- enable  input  1  when high, measurement and the window counter run.
- sample_data  input  1  asynchronous signal under test.
- bin_values  output  NUM_BINS*COUNTER_WIDTH  latched per-bin period counts; bin i is at [i*CW +: CW].
- miss_value  output  COUNTER_WIDTH  latched count of periods that match no bin.
- overflow  output  NUM_BINS+1  latched saturation flags; bit NUM_BINS is the miss counter.
- result_valid  output  1  one-cycle pulse when the outputs update.

## Operation
- sample_data passes through a 2-FF synchronizer, then a third FF for rising-edge detection.
- Elaboration-time constants per bin:
  - P_i = CLOCK_FREQUENCY/F_i.
  - LO_i = P_i*(100-D)/100.
  - HI_i = P_i*(100+D)/100.
  - No runtime dividers.
- Period counter:
  - Width is PW = clog2(max HI_i + 2).
  - Increments every enabled cycle and saturates at all-ones.
  - Resets to 1 on each detected edge.
- Arming:
  - The first edge after reset or after an enable rise only arms the block; no classification.
  - Every later edge classifies the finished period p.
- Classification: the lowest index i with LO_i <= p <= HI_i increments bin i. If no bin matches, or p is saturated, the miss counter increments.
- Saturation: an accumulator at all-ones holds its value and sets its sticky overflow bit for the current window.
- Window end:
  - The window counter runs 0..WINDOW_CYCLES-1 on enabled cycles.
  - At terminal count, accumulators and overflow bits (including a classification in that same cycle) copy to the outputs.
  - In the same edge, accumulators and overflow bits clear and result_valid pulses.
- enable low:
  - Window counter, period counter and accumulators hold.
  - The arm flag clears, so the partial period is discarded.
  - Outputs hold.
- Reset (clear low, at any time, including mid-window): all state and every output go to 0 immediately, and result_valid goes to 0. The next window starts from count 0 after clear releases.

## Timing
- Edge detected 3 clocks after a sample_data rise; classification increments on the following clock.
- Outputs and result_valid change on the clock after window terminal count. result_valid is high exactly 1 cycle per window.
- Outputs are stable for WINDOW_CYCLES enabled cycles between pulses.
- Inputs narrower than 2 clocks high or low are not guaranteed to be detected.
- No backpressure: result_valid is a strobe, and the consumer samples it or loses it.

## Structure
- Package frequency_analyzer_pkg holds:
  - a clog2 function;
  - period/limit functions (period, lo, hi from frequency, deviation, clock);
  - the 32-bit frequency field width constant.
- Sub-module period_meter contains the synchronizer, edge detect, arm flag and saturating period counter. Its outputs are period_valid and period[PW-1:0].
- The top level holds the generate loop of bin comparators, the priority select, the accumulators, the window counter and the output latch.

## Test plan
All scenarios use the defaults with WINDOW_CYCLES=100000 (periods 2500/5000/10000/20000).
- 10 kHz square wave, steady state: second and later windows give bin_values[1]=10 and all other bins, miss and overflow 0. result_valid pulses every 100000 cycles.
- 7 kHz input (p=14286): miss_value=7, all bins 0.
- Periods of 10999 and 9001 clocks each land in bin 1. A period of 11001 increments miss.
- COUNTER_WIDTH=4 with a 40 kHz input: bin_values[3]=15, overflow[3]=1, and the overflow bit is clear again in the next window after the input stops.
- clear pulled low mid-window: all outputs 0 within the same cycle, and no result_valid until 100000 enabled cycles after release.
- enable low for 50000 cycles mid-window at 10 kHz: result_valid is delayed by exactly 50000 cycles. bin_values[1] is 8 or 9 (discarded partial period plus re-arm), and miss is 0.
